// File: rtl/log_scheduler.sv
// rtl/log_scheduler.sv - sequences one mel frame through a shared single-lane log unit
// Non-positive elements bypass the log unit; unanswered requests time out to LOG_MIN.
module log_scheduler #(
  parameter int DATA_WIDTH  = 16,
  parameter int LOG_WIDTH   = 8,
  parameter int NUM_FILTERS = 26,
  parameter int TIMEOUT     = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_FILTERS*DATA_WIDTH-1:0] mel_in,
  input  logic                              mel_valid,
  output logic                              mel_ready,
  output logic                              log_req_valid,
  input  logic                              log_req_ready,
  output logic [DATA_WIDTH-1:0]             log_req_data,
  input  logic                              log_resp_valid,
  input  logic [LOG_WIDTH-1:0]              log_resp_data,
  output logic [NUM_FILTERS*LOG_WIDTH-1:0]  log_out,
  output logic                              log_valid,
  input  logic                              log_ready,
  output logic                              busy,
  output logic                              timeout_err
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [4:0] IDX_LAST = 5'(NUM_FILTERS - 1);
  localparam logic [LOG_WIDTH-1:0] LOG_MIN = {1'b1, {(LOG_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                            state;
  logic [4:0]                        idx;
  logic [TW-1:0]                     timer;
  logic [NUM_FILTERS*DATA_WIDTH-1:0] frame;
  logic [DATA_WIDTH-1:0]             elem;
  logic                              elem_pos;
  state_t                            adv_state;
  logic [4:0]                        adv_idx;

  assign elem     = frame[idx*DATA_WIDTH +: DATA_WIDTH];
  assign elem_pos = !elem[DATA_WIDTH-1] && (elem != '0);

  // Where "advance" lands: the last element finishes the frame.
  assign adv_state = (idx == IDX_LAST) ? DONE : ISSUE;
  assign adv_idx   = (idx == IDX_LAST) ? idx : idx + 5'd1;

  assign mel_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign log_valid     = (state == DONE);
  assign log_req_valid = (state == ISSUE) && elem_pos;
  assign log_req_data  = elem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      frame       <= '0;
      log_out     <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mel_valid) begin
            frame       <= mel_in;
            idx         <= '0;
            timeout_err <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!elem_pos) begin
            log_out[idx*LOG_WIDTH +: LOG_WIDTH] <= LOG_MIN;
            idx   <= adv_idx;
            state <= adv_state;
          end else if (log_req_ready) begin
            timer <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // A response arriving on the final timer cycle takes priority over the timeout.
          if (log_resp_valid) begin
            log_out[idx*LOG_WIDTH +: LOG_WIDTH] <= log_resp_data;
            idx   <= adv_idx;
            state <= adv_state;
          end else if (timer == T_LAST) begin
            log_out[idx*LOG_WIDTH +: LOG_WIDTH] <= LOG_MIN;
            timeout_err <= 1'b1;
            idx   <= adv_idx;
            state <= adv_state;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          if (log_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_log_scheduler.sv
// tb/tb_log_scheduler.sv - directed, table-driven bench for log_scheduler
module tb_log_scheduler;
  localparam int NF = 26;
  localparam int DW = 16;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NF*DW-1:0]  mel_in = '0;
  logic              mel_valid = 1'b0;
  logic              mel_ready;
  logic              log_req_valid;
  logic              log_req_ready = 1'b1;
  logic [DW-1:0]     log_req_data;
  logic              log_resp_valid = 1'b0;
  logic [LW-1:0]     log_resp_data = '0;
  logic [NF*LW-1:0]  log_out;
  logic              log_valid;
  logic              log_ready = 1'b0;
  logic              busy;
  logic              timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  log_scheduler #(.DATA_WIDTH(DW), .LOG_WIDTH(LW), .NUM_FILTERS(NF), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .mel_in(mel_in), .mel_valid(mel_valid), .mel_ready(mel_ready),
    .log_req_valid(log_req_valid), .log_req_ready(log_req_ready), .log_req_data(log_req_data),
    .log_resp_valid(log_resp_valid), .log_resp_data(log_resp_data), .log_out(log_out),
    .log_valid(log_valid), .log_ready(log_ready), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NF*DW-1:0] mel;
    logic [NF*LW-1:0] out;
    int               drop;
    int               cycles;
    logic             err;
  } vec_t;

  vec_t vt[4];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic is_pos(input logic [DW-1:0] e);
    return !e[DW-1] && (e != '0);
  endfunction

  function automatic int count_pos(input logic [NF*DW-1:0] m);
    int n = 0;
    for (int i = 0; i < NF; i++) if (is_pos(m[i*DW +: DW])) n++;
    return n;
  endfunction

  function automatic logic [DW-1:0] nth_pos(input logic [NF*DW-1:0] m, input int k);
    int n = 0;
    for (int i = 0; i < NF; i++) begin
      if (is_pos(m[i*DW +: DW])) begin
        if (n == k) return m[i*DW +: DW];
        n++;
      end
    end
    return '0;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_mel_ready"}, mel_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_log_valid"}, log_valid, 0);
    check({tag, "_req_valid"}, log_req_valid, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_log_out"}, log_out, 0);
  endtask

  task automatic accept(input logic [NF*DW-1:0] m);
    mel_in = m;
    mel_valid = 1'b1;
    @(posedge clk); #1;
    mel_valid = 1'b0;
  endtask

  task automatic release_done();
    log_ready = 1'b1;
    @(posedge clk); #1;
    log_ready = 1'b0;
  endtask

  // Log unit model: answers (request index + 10) one cycle after acceptance, except for request 'drop'.
  task automatic finish_frame(input logic [NF*DW-1:0] m, input int drop, input int abort_at,
                              input int exp_cycles, input string tag);
    int cyc = 0;
    int nreq = 0;
    int bad = 0;
    logic rnext = 1'b0;
    logic [LW-1:0] rdata = '0;
    while (!log_valid && cyc < 2000) begin
      if (abort_at >= 0 && nreq == abort_at + 1) break;
      log_resp_valid = rnext;
      log_resp_data  = rdata;
      rnext = 1'b0;
      if (log_req_valid && log_req_ready) begin
        if (log_req_data !== nth_pos(m, nreq)) bad++;
        if (nreq != drop) begin
          rnext = 1'b1;
          rdata = LW'(nreq + 10);
        end
        nreq++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    log_resp_valid = 1'b0;
    if (abort_at < 0) begin
      check({tag, "_cycles"}, cyc, exp_cycles);
      check({tag, "_log_valid"}, log_valid, 1);
      check({tag, "_req_count"}, nreq, count_pos(m));
      check({tag, "_req_order"}, bad, 0);
    end else begin
      check({tag, "_abort_reached"}, nreq, abort_at + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < NF; i++) begin
      vt[0].mel[i*DW +: DW] = DW'(0 - i);
      vt[0].out[i*LW +: LW] = 8'h80;
      vt[1].mel[i*DW +: DW] = DW'(i + 1);
      vt[1].out[i*LW +: LW] = LW'(i + 10);
      vt[2].mel[i*DW +: DW] = DW'(1000 + i);
      vt[2].out[i*LW +: LW] = (i == 5) ? 8'h80 : LW'(i + 10);
      case (i % 4)
        0, 2: begin
          vt[3].mel[i*DW +: DW] = DW'(i * 100 + 1);
          vt[3].out[i*LW +: LW] = LW'(i / 2 + 10);
        end
        1: begin
          vt[3].mel[i*DW +: DW] = '0;
          vt[3].out[i*LW +: LW] = 8'h80;
        end
        default: begin
          vt[3].mel[i*DW +: DW] = DW'(0 - 300);
          vt[3].out[i*LW +: LW] = 8'h80;
        end
      endcase
    end
    vt[0].drop = -1; vt[0].cycles = 26;  vt[0].err = 1'b0;
    vt[1].drop = -1; vt[1].cycles = 52;  vt[1].err = 1'b0;
    vt[2].drop = 5;  vt[2].cycles = 115; vt[2].err = 1'b1;
    vt[3].drop = -1; vt[3].cycles = 39;  vt[3].err = 1'b0;

    @(posedge clk); #1;
    check_reset("rst_held");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset("rst_idle");

    for (int v = 0; v < 4; v++) begin
      accept(vt[v].mel);
      finish_frame(vt[v].mel, vt[v].drop, -1, vt[v].cycles, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_log_out", v), log_out, vt[v].out);
      check($sformatf("vec%0d_timeout_err", v), timeout_err, vt[v].err);
      release_done();
    end

    // Request backpressure on element 0; untouched outputs keep the previous frame.
    log_req_ready = 1'b0;
    accept(vt[1].mel);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("hold%0d_req_valid", c), log_req_valid, 1);
      check($sformatf("hold%0d_req_data", c), log_req_data, 1);
      @(posedge clk); #1;
    end
    check("hold_prev_frame_kept", log_out, vt[3].out);
    log_req_ready = 1'b1;
    finish_frame(vt[1].mel, -1, -1, 52, "hold");
    check("hold_log_out", log_out, vt[1].out);

    // Result backpressure in DONE with a new frame already offered.
    mel_in = vt[0].mel;
    mel_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("done%0d_log_valid", c), log_valid, 1);
      check($sformatf("done%0d_mel_ready", c), mel_ready, 0);
      check($sformatf("done%0d_log_out", c), log_out, vt[1].out);
      @(posedge clk); #1;
    end
    log_ready = 1'b1;
    @(posedge clk); #1;
    log_ready = 1'b0;
    check("done_exit_idle", busy, 0);
    check("done_exit_mel_ready", mel_ready, 1);
    @(posedge clk); #1;
    mel_valid = 1'b0;
    check("next_frame_accepted", busy, 1);
    finish_frame(vt[0].mel, -1, -1, 26, "next");
    check("next_log_out", log_out, vt[0].out);
    release_done();

    // Reset while waiting on element 12, then a stray response in IDLE.
    accept(vt[1].mel);
    finish_frame(vt[1].mel, -1, 12, 0, "abort");
    check("abort_in_wait", {busy, log_req_valid}, 2'b10);
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    log_resp_valid = 1'b1;
    log_resp_data  = 8'h55;
    @(posedge clk); #1;
    log_resp_valid = 1'b0;
    check_reset("stray_resp");
    accept(vt[1].mel);
    finish_frame(vt[1].mel, -1, -1, 52, "fresh");
    check("fresh_log_out", log_out, vt[1].out);
    check("fresh_timeout_err", timeout_err, 0);
    release_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
